// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the ALU: registers one operation onto the ALU inputs,
// pulses the flag write once, then returns the result and the updated flags over valid/ready.
//
// state | meaning
// IDLE  | waiting for a request, ReqReady high
// EXEC  | operands on ALU, WF=wf_q, ALUOut captured at end of cycle
// FLAG  | WF low, post-update FlagsOut captured at end of cycle
// RESP  | response held until RspReady
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [31:0]      ReqA,
  input  logic [31:0]      ReqB,
  input  logic [4:0]       ReqFunSel,
  input  logic             ReqWF,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [4:0]       FunSel,
  output logic             WF,
  input  logic [31:0]      ALUOut,
  input  logic [3:0]       FlagsOut,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [31:0]      RspData,
  output logic [3:0]       RspFlags,
  output logic [CNT_W-1:0] OpCount
);

  typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

  state_t state, state_nxt;
  logic   wf_q;
  logic   accept;
  logic   rsp_done;

  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    WF        = 1'b0;
    RspValid  = 1'b0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = ~Reset;
        accept   = ReqValid;
        if (ReqValid) state_nxt = EXEC;
      end
      EXEC: begin
        // Not gated by Reset: the ALU samples WF on this edge regardless.
        WF        = wf_q;
        state_nxt = FLAG;
      end
      FLAG: state_nxt = RESP;
      RESP: begin
        RspValid = 1'b1;
        rsp_done = RspReady;
        if (RspReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      A        <= '0;
      B        <= '0;
      FunSel   <= '0;
      wf_q     <= 1'b0;
      RspData  <= '0;
      RspFlags <= '0;
      OpCount  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        A      <= ReqA;
        B      <= ReqB;
        FunSel <= ReqFunSel;
        wf_q   <= ReqWF;
      end
      if (state == EXEC) RspData  <= ALUOut;
      if (state == FLAG) RspFlags <= FlagsOut;
      if (rsp_done)      OpCount  <= OpCount + CNT_W'(1);
    end
  end

endmodule
